// File: rtl/issue_arb.sv
// issue_arb: N-channel issue arbiter feeding one shared PRF-read/FU issue slot.
// It offers fixed-priority or round-robin selection, masks channels whose FU
// is busy, promotes channels that keep losing, and holds the winner in a
// registered valid/ready output stage.
module issue_arb #(
  parameter int N_CH       = 3,
  parameter int WIDTH      = 64,
  parameter int MODE       = 0,
  parameter int STARVE_MAX = 8,
  parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic [N_CH-1:0]         req_valid_i,
  input  logic [N_CH*WIDTH-1:0]   req_data_i,
  input  logic [N_CH-1:0]         fu_busy_i,
  output logic [N_CH-1:0]         req_ready_o,
  output logic                    iss_valid_o,
  output logic [CH_W-1:0]         iss_ch_o,
  output logic [WIDTH-1:0]        iss_data_o,
  input  logic                    iss_ready_i
);

  // Starvation counters saturate at STARVE_MAX; keep at least one bit when disabled.
  localparam int            SW        = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] SMAX      = SW'(STARVE_MAX);
  localparam bit            STARVE_EN = (STARVE_MAX != 0);

  logic [N_CH-1:0]  eligible;
  logic [N_CH-1:0]  starved;
  logic             can_load;
  logic             grant_en;
  logic             found;
  logic             grant;
  logic [CH_W-1:0]  gidx;
  logic [WIDTH-1:0] gdata;
  logic [CH_W-1:0]  rr_ptr;
  logic [SW-1:0]    starve_cnt [N_CH];

  // Select the winning channel and drive the one-hot grant and its payload.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    eligible    = req_valid_i & ~fu_busy_i;
    can_load    = ~iss_valid_o | iss_ready_i;
    grant_en    = rst_n & ~flush_i & can_load;
    starved     = '0;
    found       = 1'b0;
    gidx        = '0;
    req_ready_o = '0;
    gdata       = '0;

    for (int i = 0; i < N_CH; i++) begin
      starved[i] = STARVE_EN && eligible[i] && (starve_cnt[i] == SMAX);
    end

    if (|starved) begin
      // Descending scan so the lowest starved index is the last one written.
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (starved[i]) begin
          found = 1'b1;
          gidx  = CH_W'(i);
        end
      end
    end else begin
      // Lowest eligible index: the fixed-priority winner and the round-robin wrap target.
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          found = 1'b1;
          gidx  = CH_W'(i);
        end
      end
      // Round-robin prefers the lowest eligible index at or above the pointer.
      if (MODE == 1) begin
        for (int i = N_CH - 1; i >= 0; i--) begin
          if (eligible[i] && (CH_W'(i) >= rr_ptr)) begin
            gidx = CH_W'(i);
          end
        end
      end
    end

    grant = found & grant_en;

    for (int i = 0; i < N_CH; i++) begin
      if (grant && (gidx == CH_W'(i))) begin
        req_ready_o[i] = 1'b1;
        gdata          = req_data_i[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register: load on grant, drop valid on consume, clear on flush/reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      iss_valid_o <= 1'b0;
      iss_ch_o    <= '0;
      iss_data_o  <= '0;
    end else if (flush_i) begin
      iss_valid_o <= 1'b0;
    end else if (grant) begin
      iss_valid_o <= 1'b1;
      iss_ch_o    <= gidx;
      iss_data_o  <= gdata;
    end else if (iss_ready_i) begin
      iss_valid_o <= 1'b0;
    end
  end

  // Round-robin pointer: moves just past the winner; stays 0 in fixed mode.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      rr_ptr <= '0;
    end else if ((MODE == 1) && grant) begin
      rr_ptr <= (gidx == CH_W'(N_CH - 1)) ? '0 : gidx + 1'b1;
    end
  end

  // Per-channel lost-arbitration counters driving the starvation override.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      // NOTE: this small counter array is reset element by element; it is state, not a RAM.
      if (!rst_n || flush_i) begin
        starve_cnt[i] <= '0;
      end else if ((grant && (gidx == CH_W'(i))) || !req_valid_i[i]) begin
        starve_cnt[i] <= '0;
      end else if (eligible[i] && can_load && grant && (starve_cnt[i] != SMAX)) begin
        starve_cnt[i] <= starve_cnt[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_issue_arb.sv
// tb_issue_arb: three issue_arb instances (fixed, round-robin, fixed with
// starvation override) driven by shared stimulus and compared every cycle
// against a behavioural model of the arbitration rules.
module tb_issue_arb;

  localparam int NC = 3;
  localparam int W  = 16;
  localparam int MODE_P [3] = '{0, 1, 0};
  localparam int SMAX_P [3] = '{0, 2, 4};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [NC-1:0] req_valid;
  logic [NC-1:0] fu_busy;
  logic [NC*W-1:0] req_data;
  logic          iss_ready;

  logic [NC-1:0] rdy [3];
  logic          vld [3];
  logic [1:0]    ch  [3];
  logic [W-1:0]  dat [3];

  int          m_valid [3];
  int          m_ch    [3];
  int          m_rr    [3];
  logic [W-1:0] m_data [3];
  int          m_cnt   [3][NC];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  issue_arb #(.N_CH(NC), .WIDTH(W), .MODE(0), .STARVE_MAX(0)) d0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .req_valid_i(req_valid),
    .req_data_i(req_data), .fu_busy_i(fu_busy), .req_ready_o(rdy[0]),
    .iss_valid_o(vld[0]), .iss_ch_o(ch[0]), .iss_data_o(dat[0]), .iss_ready_i(iss_ready));

  issue_arb #(.N_CH(NC), .WIDTH(W), .MODE(1), .STARVE_MAX(2)) d1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .req_valid_i(req_valid),
    .req_data_i(req_data), .fu_busy_i(fu_busy), .req_ready_o(rdy[1]),
    .iss_valid_o(vld[1]), .iss_ch_o(ch[1]), .iss_data_o(dat[1]), .iss_ready_i(iss_ready));

  issue_arb #(.N_CH(NC), .WIDTH(W), .MODE(0), .STARVE_MAX(4)) d2 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .req_valid_i(req_valid),
    .req_data_i(req_data), .fu_busy_i(fu_busy), .req_ready_o(rdy[2]),
    .iss_valid_o(vld[2]), .iss_ch_o(ch[2]), .iss_data_o(dat[2]), .iss_ready_i(iss_ready));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner for instance d under the current inputs, or -1 when nothing is granted.
  function automatic int model_grant(int d);
    bit elig [NC];
    if (!rst_n || flush) return -1;
    if ((m_valid[d] != 0) && !iss_ready) return -1;
    for (int i = 0; i < NC; i++) elig[i] = req_valid[i] && !fu_busy[i];
    if (SMAX_P[d] != 0)
      for (int i = 0; i < NC; i++)
        if (elig[i] && (m_cnt[d][i] == SMAX_P[d])) return i;
    for (int k = 0; k < NC; k++) begin
      int j;
      j = (MODE_P[d] == 1) ? (m_rr[d] + k) % NC : k;
      if (elig[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_update(int d);
    int g;
    bit can_load;
    g        = model_grant(d);
    can_load = (m_valid[d] == 0) || iss_ready;
    if (!rst_n) begin
      m_valid[d] = 0; m_ch[d] = 0; m_data[d] = '0; m_rr[d] = 0;
      for (int i = 0; i < NC; i++) m_cnt[d][i] = 0;
    end else if (flush) begin
      m_valid[d] = 0; m_rr[d] = 0;
      for (int i = 0; i < NC; i++) m_cnt[d][i] = 0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if ((g == i) || !req_valid[i]) m_cnt[d][i] = 0;
        else if (req_valid[i] && !fu_busy[i] && can_load && (g >= 0) && (m_cnt[d][i] < SMAX_P[d]))
          m_cnt[d][i]++;
      end
      if (g >= 0) begin
        m_valid[d] = 1;
        m_ch[d]    = g;
        m_data[d]  = req_data[g*W +: W];
      end else if (iss_ready) begin
        m_valid[d] = 0;
      end
      if ((MODE_P[d] == 1) && (g >= 0)) m_rr[d] = (g + 1) % NC;
    end
  endtask

  // Compare all instances mid-cycle, then advance DUTs and model across one edge.
  task automatic tick();
    int g;
    #3;
    for (int d = 0; d < 3; d++) begin
      g = model_grant(d);
      check($sformatf("d%0d.req_ready", d), 64'(rdy[d]), (g >= 0) ? (64'd1 << g) : 64'd0);
      check($sformatf("d%0d.iss_valid", d), 64'(vld[d]), 64'(m_valid[d]));
      check($sformatf("d%0d.iss_ch", d),    64'(ch[d]),  64'(m_ch[d]));
      check($sformatf("d%0d.iss_data", d),  64'(dat[d]), 64'(m_data[d]));
    end
    check("d1.rr_ptr", 64'(d1.rr_ptr), 64'(m_rr[1]));
    for (int i = 0; i < NC; i++)
      check($sformatf("d2.starve_cnt%0d", i), 64'(d2.starve_cnt[i]), 64'(m_cnt[2][i]));
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_update(d);
    #1;
  endtask

  task automatic drive(input logic [NC-1:0] v, input logic [NC-1:0] b, input logic r, input logic f);
    req_valid = v;
    fu_busy   = b;
    iss_ready = r;
    flush     = f;
    for (int i = 0; i < NC; i++) req_data[i*W +: W] = W'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(3'b000, 3'b000, 1'b0, 1'b0);
    for (int d = 0; d < 3; d++) begin
      m_valid[d] = 0; m_ch[d] = 0; m_rr[d] = 0; m_data[d] = '0;
      for (int i = 0; i < NC; i++) m_cnt[d][i] = 0;
    end
    @(posedge clk);
    #1;
    tick();
    drive(3'b111, 3'b000, 1'b1, 1'b0);
    tick();

    // All channels requesting with the consumer always ready.
    rst_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      drive(3'b111, 3'b000, 1'b1, 1'b0);
      tick();
    end
    // Two requesters, starvation build-up on channel 1 in the override instance.
    for (int c = 0; c < 6; c++) begin
      drive(3'b011, 3'b000, 1'b1, 1'b0);
      tick();
    end
    // Channel 0 FU busy: channel 1 must win.
    for (int c = 0; c < 3; c++) begin
      drive(3'b011, 3'b001, 1'b1, 1'b0);
      tick();
    end
    // Output stall: held entry and counters must not move.
    for (int c = 0; c < 3; c++) begin
      drive(3'b111, 3'b000, 1'b0, 1'b0);
      tick();
    end
    // Flush with a held entry and a ready consumer.
    drive(3'b111, 3'b000, 1'b1, 1'b1);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(3'b111, 3'b000, 1'b1, 1'b0);
      tick();
    end
    // Reset in the middle of traffic.
    rst_n = 1'b0;
    drive(3'b111, 3'b000, 1'b1, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomised traffic.
    for (int c = 0; c < 500; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive(NC'($urandom), ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
